// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receive path.
package ps2_pkg;

    localparam int         FRAME_W    = 11;
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'b00,
        ERR_START   = 2'b01,
        ERR_PARITY  = 2'b10,
        ERR_STOP    = 2'b11
    } err_type_t;

    // Frame data arrives LSB first, so the scan code is the bit-reverse of q[9:2].
    function automatic logic [7:0] reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus level filter for one PS/2 line; emits a one-cycle
// pulse when the filtered level falls from 1 to 0.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic fall_o
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fall_q;
    logic             fall_d;

    // The filtered level flips only once FILT_LEN successive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: shifts in 11-bit frames and validates them.
// Define PS2_BREAK_FILTER_EN to suppress frame_valid for a break code and the frame after it.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int N              = FRAME_W,
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [N-1:0] q,
    output logic         frame_valid,
    output logic         frame_err,
    output logic [1:0]   err_type,
    output logic         busy
);

    localparam int BIT_W = $clog2(N + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [N-2:0]     shift_q;
    logic [N-2:0]     shift_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic [N-1:0]     q_q;
    logic [N-1:0]     q_d;
    logic             frame_valid_q;
    logic             frame_valid_d;
    logic             frame_err_q;
    logic             frame_err_d;
    err_type_t        err_type_q;
    err_type_t        err_type_d;
    logic             busy_q;
    logic             busy_d;
    logic             data_sync1_q;
    logic             data_sync2_q;
`ifdef PS2_BREAK_FILTER_EN
    logic             break_pending_q;
    logic             break_pending_d;
`endif

    logic             clk_fall;
    logic [N-1:0]     new_frame;
    logic             stop_ok;
    logic             parity_ok;

    ps2_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_clk_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (ps2_clk),
        .fall_o (clk_fall)
    );

    // On the stop-bit fall the frame is judged straight away, so the result
    // registers are already showing it during the single CHECK cycle.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        q_d           = q_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_type_d    = err_type_q;
        busy_d        = busy_q;
`ifdef PS2_BREAK_FILTER_EN
        break_pending_d = break_pending_q;
`endif
        new_frame = {shift_q, data_sync2_q};
        stop_ok   = new_frame[0];
        parity_ok = ^new_frame[N-2:1];

        unique case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                busy_d    = 1'b0;
                if (clk_fall) begin
                    if (!data_sync2_q) begin
                        state_d   = RECV;
                        shift_d   = '0;
                        bit_cnt_d = BIT_W'(1);
                        busy_d    = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_type_d  = ERR_START;
                    end
                end
            end
            RECV: begin
                if (clk_fall) begin
                    tmo_cnt_d = '0;
                    shift_d   = new_frame[N-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(N - 1)) begin
                        state_d = CHECK;
                        if (!stop_ok) begin
                            frame_err_d = 1'b1;
                            err_type_d  = ERR_STOP;
                        end else if (!parity_ok) begin
                            frame_err_d = 1'b1;
                            err_type_d  = ERR_PARITY;
                        end else begin
                            q_d = new_frame;
`ifdef PS2_BREAK_FILTER_EN
                            if (break_pending_q) begin
                                break_pending_d = 1'b0;
                            end else if (reverse8(new_frame[N-2:2]) == BREAK_CODE) begin
                                break_pending_d = 1'b1;
                            end else begin
                                frame_valid_d = 1'b1;
                            end
`else
                            frame_valid_d = 1'b1;
`endif
                        end
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    tmo_cnt_d   = '0;
                    busy_d      = 1'b0;
                    frame_err_d = 1'b1;
                    err_type_d  = ERR_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef PS2_BREAK_FILTER_EN
        if (frame_err_d) begin
            break_pending_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            q_q           <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_type_q    <= ERR_TIMEOUT;
            busy_q        <= 1'b0;
            data_sync1_q  <= 1'b1;
            data_sync2_q  <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            break_pending_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            q_q           <= q_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_type_q    <= err_type_d;
            busy_q        <= busy_d;
            data_sync1_q  <= ps2_data;
            data_sync2_q  <= data_sync1_q;
`ifdef PS2_BREAK_FILTER_EN
            break_pending_q <= break_pending_d;
`endif
        end
    end

    assign q           = q_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_type    = err_type_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table-driven frames, hand-written corner sequences and
// randomised frames scored against a frame-level reference model.
module tb_ps2_rx;

    localparam int FILT   = 4;
    localparam int TMO    = 500;
    localparam int HALF   = 20;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] q;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_type;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    int last_fall_cyc = 0;
    int valid_base;
    int err_base;
    logic [1:0]  last_err = 2'b00;
    logic [10:0] model_q = '0;
    logic        model_brk = 1'b0;

    typedef struct {
        logic [7:0]  scan;
        logic        flip_par;
        logic        stop;
        int          exp_v;
        int          exp_e;
        logic [1:0]  exp_t;
        logic [10:0] exp_q;
    } vec_t;

    vec_t vecs[9];

    ps2_rx #(
        .N              (11),
        .FILT_LEN       (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .q           (q),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_type    (err_type),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc  = cyc;
            last_err = err_type;
        end
        if (frame_valid || frame_err)
            checkValue("exclusive_pulse", {31'b0, frame_valid & frame_err}, 32'd0);
    end

    // Frame in q order: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] makeFrame(input logic [7:0] scan, input logic flip_par,
                                              input logic stop);
        logic [10:0] f;
        int ones;
        f    = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[9-i] = scan[i];
            ones += int'(scan[i]);
        end
        f[1] = ((ones % 2) == 0) ^ flip_par;
        f[0] = stop;
        return f;
    endfunction

    // Reference model: decides the outcome of a complete frame from its bits.
    task automatic modelFrame(input logic [10:0] f, output int ev, output int ee,
                              output logic [1:0] et);
        ev = 0;
        ee = 0;
        et = last_err;
        if (f[0] == 1'b0) begin
            ee = 1;
            et = 2'b11;
        end else if (($countones(f[9:1]) % 2) == 0) begin
            ee = 1;
            et = 2'b10;
        end else begin
            model_q = f;
`ifdef PS2_BREAK_FILTER_EN
            begin
                logic [7:0] scan;
                for (int i = 0; i < 8; i++) scan[i] = f[9-i];
                if (model_brk) model_brk = 1'b0;
                else if (scan == 8'hF0) model_brk = 1'b1;
                else ev = 1;
            end
`else
            ev = 1;
`endif
        end
`ifdef PS2_BREAK_FILTER_EN
        if (ee != 0) model_brk = 1'b0;
`endif
    endtask

    task automatic sendBit(input logic b, input logic glitch);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        if (glitch) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [10:0] f, input logic glitch);
        valid_base = valid_cnt;
        err_base   = err_cnt;
        for (int i = 10; i >= 0; i--) sendBit(f[i], glitch);
        ps2_data = 1'b1;
        repeat (60) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int exp_v, input int exp_e,
                               input logic [1:0] exp_t, input logic [10:0] exp_q);
        checkValue({name, "_valid_pulses"}, valid_cnt - valid_base, exp_v);
        checkValue({name, "_err_pulses"}, err_cnt - err_base, exp_e);
        if (exp_e != 0) checkValue({name, "_err_type"}, {30'b0, last_err}, {30'b0, exp_t});
        checkValue({name, "_q"}, {21'b0, q}, {21'b0, exp_q});
        checkValue({name, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int ev;
        int ee;
        logic [1:0]  et;
        logic [10:0] f;

        vecs[0] = '{8'h16, 1'b0, 1'b1, 1, 0, 2'b00, 11'b00110100001};
        vecs[1] = '{8'h16, 1'b1, 1'b1, 0, 1, 2'b10, 11'b00110100001};
        vecs[2] = '{8'h16, 1'b0, 1'b0, 0, 1, 2'b11, 11'b00110100001};
        vecs[3] = '{8'h1E, 1'b0, 1'b1, 1, 0, 2'b00, 11'b00111100011};
        vecs[4] = '{8'h1C, 1'b1, 1'b0, 0, 1, 2'b11, 11'b00111100011};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1, 0, 2'b00, 11'b00000000011};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1, 0, 2'b00, 11'b01111111111};
        vecs[7] = '{8'h29, 1'b1, 1'b1, 0, 1, 2'b10, 11'b01111111111};
        vecs[8] = '{8'h29, 1'b0, 1'b1, 1, 0, 2'b00, 11'b01001010001};

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        checkValue("reset_q", {21'b0, q}, 32'd0);
        checkValue("reset_valid", {31'b0, frame_valid}, 32'd0);
        checkValue("reset_err", {31'b0, frame_err}, 32'd0);
        checkValue("reset_err_type", {30'b0, err_type}, 32'd0);
        checkValue("reset_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] table-driven frames");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(makeFrame(vecs[i].scan, vecs[i].flip_par, vecs[i].stop), 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_t,
                        vecs[i].exp_q);
            if (vecs[i].exp_v != 0) begin
                checkValue($sformatf("vec%0d_latency_lo", i),
                           {31'b0, (valid_cyc - last_fall_cyc) >= FILT + 1}, 32'd1);
                checkValue($sformatf("vec%0d_latency_hi", i),
                           {31'b0, (valid_cyc - last_fall_cyc) <= FILT + 6}, 32'd1);
            end
            model_q = vecs[i].exp_q;
        end

        $display("[TB] start bit error");
        valid_base = valid_cnt;
        err_base   = err_cnt;
        sendBit(1'b1, 1'b0);
        repeat (60) @(negedge clk);
        checkOutput("start_err", 0, 1, 2'b01, 11'b01001010001);
        model_brk = 1'b0;

        $display("[TB] mid-frame timeout");
        valid_base = valid_cnt;
        err_base   = err_cnt;
        f = makeFrame(8'h16, 1'b0, 1'b1);
        for (int i = 10; i >= 6; i--) sendBit(f[i], 1'b0);
        ps2_data = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        checkOutput("timeout", 0, 1, 2'b00, 11'b01001010001);
        checkValue("timeout_at_lo", {31'b0, (err_cyc - last_fall_cyc) >= TMO + FILT}, 32'd1);
        checkValue("timeout_at_hi", {31'b0, (err_cyc - last_fall_cyc) <= TMO + FILT + 6}, 32'd1);
        applyStimulus(makeFrame(8'h16, 1'b0, 1'b1), 1'b0);
        checkOutput("after_timeout", 1, 0, 2'b00, 11'b00110100001);

        $display("[TB] glitches on ps2_clk");
        applyStimulus(makeFrame(8'h1E, 1'b0, 1'b1), 1'b0);
        applyStimulus(makeFrame(8'h16, 1'b0, 1'b1), 1'b1);
        checkOutput("glitch", 1, 0, 2'b00, 11'b00110100001);

        $display("[TB] reset mid-frame");
        for (int i = 10; i >= 7; i--) sendBit(f[i], 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checkValue("midrst_q", {21'b0, q}, 32'd0);
        checkValue("midrst_valid", {31'b0, frame_valid}, 32'd0);
        checkValue("midrst_err", {31'b0, frame_err}, 32'd0);
        checkValue("midrst_err_type", {30'b0, err_type}, 32'd0);
        checkValue("midrst_busy", {31'b0, busy}, 32'd0);
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_err = 2'b00;
        repeat (20) @(negedge clk);
        applyStimulus(makeFrame(8'h16, 1'b0, 1'b1), 1'b0);
        checkOutput("after_reset", 1, 0, 2'b00, 11'b00110100001);
        model_q   = 11'b00110100001;
        model_brk = 1'b0;

        $display("[TB] break code then make code");
        valid_base = valid_cnt;
        err_base   = err_cnt;
        applyStimulus(makeFrame(8'hF0, 1'b0, 1'b1), 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        checkOutput("break_f0", 0, 0, 2'b00, 11'b00000111111);
`else
        checkOutput("break_f0", 1, 0, 2'b00, 11'b00000111111);
`endif
        applyStimulus(makeFrame(8'h16, 1'b0, 1'b1), 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        checkOutput("break_16", 0, 0, 2'b00, 11'b00110100001);
`else
        checkOutput("break_16", 1, 0, 2'b00, 11'b00110100001);
`endif
        model_q   = 11'b00110100001;
        model_brk = 1'b0;

        $display("[TB] randomised frames");
        for (int n = 0; n < 24; n++) begin
            logic [7:0] scan;
            int kind;
            scan = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) scan = 8'hF0;
            kind = $urandom_range(0, 3);
            f = makeFrame(scan, kind == 0, kind != 1);
            modelFrame(f, ev, ee, et);
            applyStimulus(f, 1'($urandom_range(0, 1)));
            checkOutput($sformatf("rand%0d", n), ev, ee, et, model_q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
